// File: rtl/uart_resp_serializer.sv
// Word FIFO feeding a byte serializer that streams 32-bit responses MSB first to a UART.
// Define RESP_CHECKSUM_EN to append an XOR checksum byte after each word.
module uart_resp_serializer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [31:0]                s_word_tdata,
    input  logic                       s_word_tvalid,
    output logic                       s_word_tready,
    output logic [7:0]                 m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       busy
);
    // Handshake: a transfer happens on a rising edge where valid && ready; the
    // source holds data and valid steady until that edge.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

`ifdef RESP_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_IDX = 3'd3;
`endif

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [0:0]    state;
    logic [2:0]    idx;
    logic [31:0]   word_q;
    logic [7:0]    tdata_q;
    logic          tvalid_q;

    logic          push;
    logic          pop;
    logic          hs;
    logic          word_done;
    logic [31:0]   head;

    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [2:0] i);
        logic [7:0] b;
        b = 8'h00;
        case (i)
            3'd0: b = w[31:24];
            3'd1: b = w[23:16];
            3'd2: b = w[15:8];
            3'd3: b = w[7:0];
`ifdef RESP_CHECKSUM_EN
            3'd4: b = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign s_word_tready = (level_q != FULL_LEVEL);
    assign push          = s_word_tvalid && s_word_tready && !flush;
    assign hs            = tvalid_q && m_axis_tready;
    assign word_done     = (state == SEND) && hs && (idx == LAST_IDX);
    assign pop           = !flush && (level_q != '0) && ((state == IDLE) || word_done);
    assign head          = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= s_word_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            level_q  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            idx      <= 3'd0;
            word_q   <= 32'h0;
            tvalid_q <= 1'b0;
            tdata_q  <= 8'h00;
        end else if (flush) begin
            // The byte currently on the output is dropped along with the queue.
            state    <= IDLE;
            level_q  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            idx      <= 3'd0;
            tvalid_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                word_q   <= head;
                idx      <= 3'd0;
                state    <= SEND;
                tvalid_q <= 1'b1;
                tdata_q  <= head[31:24];
            end else if (word_done) begin
                state    <= IDLE;
                idx      <= 3'd0;
                tvalid_q <= 1'b0;
            end else if ((state == SEND) && hs) begin
                idx     <= idx + 3'd1;
                tdata_q <= byte_sel(word_q, idx + 3'd1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign level         = level_q;
    assign busy          = (level_q != '0) || (state == SEND);

endmodule
